// File: rtl/wallace_cpa_serial.sv
// Final carry-propagate adder of the Wallace multiplier: resolves sum/carry vectors CHUNK bits per cycle.
// Optional macro WALLACE_CPA_EARLY_DONE_EN finishes as soon as no higher chunk can change the result.
module wallace_cpa_serial #(
    parameter int WIDTH = 2048,
    parameter int CHUNK = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_vec,
    input  logic [WIDTH-1:0] carry_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("wallace_cpa_serial: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [31:0]       base_s;
    logic [CHUNK:0]    chunk_sum_s;
`ifdef WALLACE_CPA_EARLY_DONE_EN
    logic [NCHUNK-1:0] nz_q, nz_d, nz_s;
    logic              upper_nz_s;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign cout      = cout_q;

    // Current chunk addition, CHUNK+1 bits wide so the carry is kept separately.
    always_comb begin
        base_s      = 32'(idx_q) * 32'(CHUNK);
        chunk_sum_s = {1'b0, a_q[base_s +: CHUNK]} + {1'b0, b_q[base_s +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry_q};
    end

`ifdef WALLACE_CPA_EARLY_DONE_EN
    // Per-chunk non-zero flags of the incoming operands and the "work remains above idx" test.
    always_comb begin
        nz_s = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            nz_s[i] = (|sum_vec[i*CHUNK +: CHUNK]) | (|carry_vec[i*CHUNK +: CHUNK]);
        end
        upper_nz_s = |(nz_q >> (32'(idx_q) + 32'd1));
    end
`endif

    // Next-state and datapath control for IDLE -> ADD -> DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
`ifdef WALLACE_CPA_EARLY_DONE_EN
        nz_d     = nz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = sum_vec;
                    b_d      = carry_vec;
                    result_d = '0;
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    cout_d   = 1'b0;
`ifdef WALLACE_CPA_EARLY_DONE_EN
                    nz_d     = nz_s;
`endif
                    state_d  = S_ADD;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_ADD: begin
                result_d[base_s +: CHUNK] = chunk_sum_s[CHUNK-1:0];
                carry_d = chunk_sum_s[CHUNK];
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_sum_s[CHUNK];
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
`ifdef WALLACE_CPA_EARLY_DONE_EN
                    // Upper result chunks were zeroed at capture, so nothing is left to add.
                    if (!chunk_sum_s[CHUNK] && !upper_nz_s) begin
                        cout_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADD;
                    end
`else
                    state_d = S_ADD;
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
`ifdef WALLACE_CPA_EARLY_DONE_EN
            nz_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
`ifdef WALLACE_CPA_EARLY_DONE_EN
            nz_q     <= nz_d;
`endif
        end
    end

endmodule

// File: tb/tb_wallace_cpa_serial.sv
// Scoreboard bench for wallace_cpa_serial at WIDTH=16, CHUNK=4 with directed vectors.
module tb_wallace_cpa_serial;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum_vec;
    logic [15:0] carry_vec;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;

    typedef struct {
        logic [15:0] r;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   seen     = 1'b0;

`ifdef WALLACE_CPA_EARLY_DONE_EN
    localparam int LAT_00FF = 3;
    localparam int LAT_0003 = 1;
`else
    localparam int LAT_00FF = 4;
    localparam int LAT_0003 = 4;
`endif

    wallace_cpa_serial #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: compare the first cycle of each out_valid pulse against the scoreboard.
    always @(negedge clk) begin
        if (out_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {16'd0, result}, {16'd0, e.r});
                chk("cout", {31'd0, cout}, {31'd0, e.c});
                chk("latency", cyc - e.acc, e.lat);
            end
        end
        if (!out_valid) seen = 1'b0;
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit push,
                        input logic [15:0] er, input logic ec, input int lat);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_in_ready_timeout", 32'd0, 32'd1);
        sum_vec   = a;
        carry_vec = b;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        sum_vec   = 16'($urandom);
        carry_vec = 16'($urandom);
        if (push) sb.push_back('{er, ec, lat, cyc});
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sum_vec   = 16'h1234;
        carry_vec = 16'h0001;

        // Reset with in_valid asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Carry across chunk boundaries and overflow into cout
        send(16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, LAT_00FF);
        wait_empty();
        send(16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 4);
        wait_empty();
        send(16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 4);
        wait_empty();

        // Backpressure with ignored input pulses
        out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b1, 16'h2345, 1'b0, 4);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        chk("bp_reached_done", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            sum_vec   = 16'hFFFF;
            carry_vec = 16'hFFFF;
            @(posedge clk);
            @(negedge clk);
            chk("bp_result", {16'd0, result}, 32'h2345);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk("bp_no_phantom_op", {31'd0, out_valid}, 32'd0);
        wait_empty();

        // Reset in the middle of ADD
        send(16'hAAAA, 16'h5555, 1'b0, 16'h0000, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", {16'd0, result}, 32'd0);
        rst_n = 1'b1;
        send(16'h0F0F, 16'h00F1, 1'b1, 16'h1000, 1'b0, 4);
        wait_empty();

        // Early-done candidates
        send(16'h0003, 16'h0004, 1'b1, 16'h0007, 1'b0, LAT_0003);
        wait_empty();
        send(16'h0F00, 16'h0100, 1'b1, 16'h1000, 1'b0, 4);
        wait_empty();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
